ace_snoop_responder: RTL and testbench

Cache-side ACE snoop responder: the master-side end of the snoop AC/CR/CD interface driven by the coherency control unit. It accepts one AC snoop request at a time and looks the line up in the local D-cache through a simple lookup/update port. It returns a CR response and, when data transfer is required, streams the cache line as CD beats. One instance sits per cached master, between the CCU snoop port and the cache controller.

---
 rtl/ace_snoop_responder.sv | 160 ++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: ACE snoop AC/CR/CD responder in front of a cache lookup/update port.
// Define ACE_SNOOP_RESP_CRITICAL_WORD_FIRST_EN to start CD at the snooped word.
package ace_snoop_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
    logic [2:0]  prot;
  } ac_chan_t;
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;
  typedef struct packed {
    ac_chan_t ac;
    logic     ac_valid;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;
  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned DcacheLineWidth = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiAddrWidth = 64,
  parameter type snoop_req_t = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lkp_valid_o,
  output logic [AxiAddrWidth-1:0]    lkp_addr_o,
  input  logic                       lkp_ready_i,
  input  logic                       lkp_rsp_valid_i,
  input  logic                       lkp_hit_i,
  input  logic                       lkp_dirty_i,
  input  logic                       lkp_shared_i,
  input  logic [DcacheLineWidth-1:0] lkp_line_i,
  output logic                       upd_valid_o,
  output logic                       upd_inval_o,
  input  logic                       upd_ready_i
);
  localparam int unsigned Words = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned OffW = $clog2(DcacheLineWidth / 8);
  localparam int unsigned WordW = $clog2(AxiDataWidth / 8);
  localparam int unsigned CntW = Words > 1 ? $clog2(Words) : 1;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] WAIT_RSP = 3'd2;
  localparam logic [2:0] UPDATE = 3'd3;
  localparam logic [2:0] SEND_CR = 3'd4;
  localparam logic [2:0] SEND_CD = 3'd5;
  logic [2:0] state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [3:0] snoop_q, snoop_d;
  logic [DcacheLineWidth-1:0] line_q, line_d;
  logic [4:0] cr_q, cr_d;
  logic inval_q, inval_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic init_q;
  logic [CntW-1:0] start_w, nxt_w;
  logic last_w, ro, rd_s, ru, cs, ci, mi, known, dt_w, pd_w, is_w, wu_w, inv_w, upd_w;
  logic unused_in;
  assign unused_in = ^{snoop_req_i.ac.prot, addr_q[OffW-1:0]};
`ifdef ACE_SNOOP_RESP_CRITICAL_WORD_FIRST_EN
  assign start_w = addr_q[OffW-1:WordW];
`else
  assign start_w = '0;
`endif
  assign nxt_w = (cnt_q == CntW'(Words - 1)) ? '0 : cnt_q + 1'b1;
  assign last_w = nxt_w == start_w;
  assign ro = snoop_q == 4'b0000;
  assign rd_s = snoop_q inside {4'b0001, 4'b0010, 4'b0011};
  assign ru = snoop_q == 4'b0111;
  assign cs = snoop_q == 4'b1000;
  assign ci = snoop_q == 4'b1001;
  assign mi = snoop_q == 4'b1101;
  assign known = ro | rd_s | ru | cs | ci | mi;
  assign dt_w = lkp_hit_i & (ro | rd_s | ru | ((cs | ci) & lkp_dirty_i));
  assign pd_w = lkp_hit_i & lkp_dirty_i & (rd_s | ru | cs | ci);
  assign is_w = lkp_hit_i & (ro | rd_s | cs);
  assign wu_w = lkp_hit_i & known & ~lkp_shared_i;
  assign inv_w = ru | ci | mi;
  assign upd_w = lkp_hit_i & (inv_w | ((rd_s | cs) & lkp_dirty_i));
  assign lkp_valid_o = state_q == LOOKUP;
  assign lkp_addr_o = {addr_q[AxiAddrWidth-1:OffW], OffW'(0)};
  assign upd_valid_o = state_q == UPDATE;
  assign upd_inval_o = inval_q;
  always_comb begin
    snoop_resp_o = '0;
    snoop_resp_o.ac_ready = init_q & (state_q == IDLE);
    snoop_resp_o.cr_valid = state_q == SEND_CR;
    snoop_resp_o.cr_resp = cr_q;
    snoop_resp_o.cd_valid = state_q == SEND_CD;
    snoop_resp_o.cd.data = line_q[cnt_q*AxiDataWidth +: AxiDataWidth];
    snoop_resp_o.cd.last = (state_q == SEND_CD) & last_w;
  end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    snoop_d = snoop_q;
    line_d = line_q;
    cr_d = cr_q;
    inval_d = inval_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (snoop_req_i.ac_valid && init_q) begin
        addr_d = snoop_req_i.ac.addr[AxiAddrWidth-1:0];
        snoop_d = snoop_req_i.ac.snoop;
        state_d = LOOKUP;
      end
      LOOKUP: state_d = lkp_ready_i ? WAIT_RSP : LOOKUP;
      WAIT_RSP: if (lkp_rsp_valid_i) begin
        line_d = lkp_line_i;
        cr_d = {wu_w, is_w, pd_w, 1'b0, dt_w};
        inval_d = inv_w;
        state_d = upd_w ? UPDATE : SEND_CR;
      end
      UPDATE: state_d = upd_ready_i ? SEND_CR : UPDATE;
      SEND_CR: if (snoop_req_i.cr_ready) begin
        cnt_d = start_w;
        state_d = cr_q[0] ? SEND_CD : IDLE;
      end
      SEND_CD: if (snoop_req_i.cd_ready) begin
        cnt_d = nxt_w;
        state_d = last_w ? IDLE : SEND_CD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q <= '0;
      snoop_q <= '0;
      line_q <= '0;
      cr_q <= '0;
      inval_q <= 1'b0;
      cnt_q <= '0;
      init_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      snoop_q <= snoop_d;
      line_q <= line_d;
      cr_q <= cr_d;
      inval_q <= inval_d;
      cnt_q <= cnt_d;
      init_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: scoreboard bench for ace_snoop_responder with 128-bit and 256-bit line instances.
module tb_ace_snoop_responder;
  import ace_snoop_pkg::*;
  typedef struct {
    logic [1:0]  kind;
    logic        last;
    logic [63:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;
  snoop_req_t req[2];
  snoop_resp_t resp[2];
  logic lkp_valid[2], lkp_ready[2], rsp_valid[2], hit[2], dirty[2], shared[2];
  logic upd_valid[2], upd_inval[2], upd_ready[2];
  logic [63:0] lkp_addr[2];
  logic [255:0] line[2];
  exp_t sbq[2][$];
  int checks = 0;
  int errors = 0;
  logic pend[2];
  logic [63:0] pd[2];

  ace_snoop_responder #(.DcacheLineWidth(128)) u128 (
    .clk_i(clk), .rst_ni(rst_ni), .snoop_req_i(req[0]), .snoop_resp_o(resp[0]),
    .lkp_valid_o(lkp_valid[0]), .lkp_addr_o(lkp_addr[0]), .lkp_ready_i(lkp_ready[0]),
    .lkp_rsp_valid_i(rsp_valid[0]), .lkp_hit_i(hit[0]), .lkp_dirty_i(dirty[0]),
    .lkp_shared_i(shared[0]), .lkp_line_i(line[0][127:0]), .upd_valid_o(upd_valid[0]),
    .upd_inval_o(upd_inval[0]), .upd_ready_i(upd_ready[0]));

  ace_snoop_responder #(.DcacheLineWidth(256)) u256 (
    .clk_i(clk), .rst_ni(rst_ni), .snoop_req_i(req[1]), .snoop_resp_o(resp[1]),
    .lkp_valid_o(lkp_valid[1]), .lkp_addr_o(lkp_addr[1]), .lkp_ready_i(lkp_ready[1]),
    .lkp_rsp_valid_i(rsp_valid[1]), .lkp_hit_i(hit[1]), .lkp_dirty_i(dirty[1]),
    .lkp_shared_i(shared[1]), .lkp_line_i(line[1]), .upd_valid_o(upd_valid[1]),
    .upd_inval_o(upd_inval[1]), .upd_ready_i(upd_ready[1]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [1:0] k, input logic l, input logic [63:0] v);
    exp_t e;
    e.kind = k;
    e.last = l;
    e.val = v;
    sbq[d].push_back(e);
  endtask

  task automatic pop(input int d, input string nm, input logic [1:0] k, input logic l, input logic [63:0] v);
    exp_t e;
    if (sbq[d].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_d%0d: unexpected handshake got %0h expected none", nm, d, v);
    end else begin
      e = sbq[d].pop_front();
      chk($sformatf("%s_d%0d", nm, d), {61'b0, k, l, v}, {61'b0, e.kind, e.last, e.val});
    end
  endtask

  // Monitor: every handshake is matched against the head of that instance's queue.
  always @(negedge clk) begin
    if (!rst_ni) begin
      pend <= '{1'b0, 1'b0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (upd_valid[d] && upd_ready[d]) pop(d, "upd", 2'd1, 1'b0, {63'b0, upd_inval[d]});
        if (resp[d].cr_valid && req[d].cr_ready) pop(d, "cr", 2'd2, 1'b0, {59'b0, resp[d].cr_resp});
        if (resp[d].cd_valid && req[d].cd_ready) pop(d, "cd", 2'd3, resp[d].cd.last, resp[d].cd.data);
        if (pend[d]) chk($sformatf("cd_stable_d%0d", d), {63'b0, resp[d].cd_valid, resp[d].cd.data}, {63'b0, 1'b1, pd[d]});
        pend[d] <= resp[d].cd_valid && !req[d].cd_ready;
        pd[d] <= resp[d].cd.data;
      end
    end
  end

  task automatic init_inputs(input int d);
    req[d] = '0;
    req[d].cr_ready = 1'b1;
    req[d].cd_ready = 1'b1;
    lkp_ready[d] = 1'b1;
    rsp_valid[d] = 1'b0;
    hit[d] = 1'b0;
    dirty[d] = 1'b0;
    shared[d] = 1'b0;
    line[d] = '0;
    upd_ready[d] = 1'b1;
  endtask

  task automatic check_reset(input int d);
    chk($sformatf("rst_ac_ready_d%0d", d), resp[d].ac_ready, 0);
    chk($sformatf("rst_cr_valid_d%0d", d), resp[d].cr_valid, 0);
    chk($sformatf("rst_cr_resp_d%0d", d), resp[d].cr_resp, 0);
    chk($sformatf("rst_cd_valid_d%0d", d), resp[d].cd_valid, 0);
    chk($sformatf("rst_cd_last_d%0d", d), resp[d].cd.last, 0);
    chk($sformatf("rst_cd_data_d%0d", d), resp[d].cd.data, 0);
    chk($sformatf("rst_lkp_valid_d%0d", d), lkp_valid[d], 0);
    chk($sformatf("rst_upd_valid_d%0d", d), upd_valid[d], 0);
  endtask

  function automatic logic [255:0] mkline(input int s);
    logic [255:0] r;
    for (int k = 0; k < 4; k++) r[k*64 +: 64] = {32'(s), 24'hC0FFEE, 8'(k)};
    return r;
  endfunction

  // upd: 0 none, 1 make clean-shared, 2 invalidate
  task automatic do_snoop(input int d, input logic [63:0] addr, input logic [3:0] sn,
                          input logic h, input logic dt, input logic sh, input logic [255:0] ln,
                          input logic [4:0] cr, input int upd, input bit stall, input bit abort);
    int words;
    int start;
    int w;
    bit ok;
    words = d ? 4 : 2;
    start = 0;
`ifdef ACE_SNOOP_RESP_CRITICAL_WORD_FIRST_EN
    start = int'(addr >> 3) % words;
`endif
    if (upd != 0) push(d, 2'd1, 1'b0, {63'b0, upd == 2});
    push(d, 2'd2, 1'b0, {59'b0, cr});
    if (cr[0]) for (int k = 0; k < (abort ? 1 : words); k++) begin
      w = (start + k) % words;
      push(d, 2'd3, k == words - 1, ln[w*64 +: 64]);
    end
    if (stall) req[d].cd_ready = 1'b0;
    @(posedge clk); #1;
    req[d].ac_valid = 1'b1;
    req[d].ac.addr = addr;
    req[d].ac.snoop = sn;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = resp[d].ac_ready;
    end
    chk("ac_accept", ok, 1);
    @(posedge clk); #1;
    req[d].ac_valid = 1'b0;
    @(negedge clk);
    chk("lkp_valid", lkp_valid[d], 1);
    chk("lkp_addr", lkp_addr[d], addr & (d ? ~64'h1F : ~64'hF));
    @(posedge clk); #1;
    rsp_valid[d] = 1'b1;
    hit[d] = h;
    dirty[d] = dt;
    shared[d] = sh;
    line[d] = ln;
    @(posedge clk); #1;
    rsp_valid[d] = 1'b0;
    hit[d] = ~h;
    line[d] = ~ln;
    @(negedge clk);
    chk("cr_or_upd_latency", {upd_valid[d], resp[d].cr_valid}, {upd != 0, upd == 0});
    if (abort) begin
      @(posedge clk);
      @(posedge clk); #2;
      rst_ni = 1'b0;
      #1;
      check_reset(d);
      init_inputs(d);
      chk("abort_queue", sbq[d].size(), 0);
      @(posedge clk); #1;
      rst_ni = 1'b1;
      @(negedge clk);
      chk("ac_ready_held_low", resp[d].ac_ready, 0);
      @(negedge clk);
      chk("ac_ready_after_release", resp[d].ac_ready, 1);
      return;
    end
    if (!cr[0] && upd == 0) begin
      @(negedge clk);
      chk("ac_ready_after_cr", resp[d].ac_ready, 1);
    end
    if (stall) repeat (6) @(posedge clk);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (stall) req[d].cd_ready = ~req[d].cd_ready;
      @(negedge clk);
      ok = resp[d].ac_ready && sbq[d].size() == 0;
    end
    chk($sformatf("done_%0h", addr), ok, 1);
    req[d].cd_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    init_inputs(0);
    init_inputs(1);
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ac_ready_first_d0", resp[0].ac_ready, 0);
    @(negedge clk);
    chk("ac_ready_up_d0", resp[0].ac_ready, 1);
    chk("ac_ready_up_d1", resp[1].ac_ready, 1);
    do_snoop(0, 64'h2000, 4'b0001, 1, 1, 0, mkline(1), 5'b11101, 1, 0, 0);
    do_snoop(0, 64'h2040, 4'b0111, 1, 0, 1, mkline(2), 5'b00001, 2, 0, 0);
    do_snoop(0, 64'h2080, 4'b1101, 1, 0, 1, mkline(3), 5'b00000, 2, 0, 0);
    do_snoop(0, 64'h20C0, 4'b0001, 0, 1, 0, mkline(4), 5'b00000, 0, 0, 0);
    do_snoop(0, 64'h2100, 4'b0010, 1, 0, 0, mkline(5), 5'b11001, 0, 1, 0);
    do_snoop(0, 64'h2140, 4'b1000, 1, 1, 1, mkline(6), 5'b01101, 1, 0, 0);
    do_snoop(0, 64'h2180, 4'b1001, 1, 0, 0, mkline(7), 5'b10000, 2, 0, 0);
    do_snoop(0, 64'h21C0, 4'b0101, 1, 1, 0, mkline(8), 5'b00000, 0, 0, 0);
    do_snoop(1, 64'h1008, 4'b0000, 1, 0, 1, mkline(9), 5'b01001, 0, 0, 0);
    do_snoop(0, 64'h2200, 4'b0000, 1, 0, 0, mkline(10), 5'b11001, 0, 0, 1);
    do_snoop(0, 64'h2240, 4'b0011, 1, 1, 1, mkline(11), 5'b01101, 1, 0, 0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
